// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: enables, bubbles and redirect are combinational from state and hazards.
// Zero-cycle decision latency; the FSM only remembers multi-cycle hazards (I/D refill, multiply).
module pipe_stall_ctrl #(
  parameter int MUL_LAT     = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   icache_miss,
  input  logic                   icache_ready,
  input  logic                   dcache_miss,
  input  logic                   dcache_ready,
  input  logic                   mul_start,
  input  logic                   load_use,
  input  logic                   branch_taken,
  output logic                   en_f,
  output logic                   en_d,
  output logic                   en_a,
  output logic                   en_m,
  output logic                   en_w,
  output logic                   bubble_d,
  output logic                   bubble_a,
  output logic                   bubble_m,
  output logic                   bubble_w,
  output logic                   redirect,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, IMISS, DMISS, MUL} state_t;

  // Control word: {en_f,en_d,en_a,en_m,en_w, bubble_d,bubble_a,bubble_m,bubble_w, redirect}
  localparam logic [9:0] CTL_RUN   = 10'b11111_0000_0;
  localparam logic [9:0] CTL_DMISS = 10'b00001_0001_0;
  localparam logic [9:0] CTL_MUL   = 10'b00011_0010_0;
  localparam logic [9:0] CTL_BR    = 10'b11111_1100_1;
  localparam logic [9:0] CTL_LU    = 10'b00111_0100_0;
  localparam logic [9:0] CTL_IMISS = 10'b01111_1000_0;

  localparam logic [3:0] MUL_INIT   = 4'(MUL_LAT - 1);
  localparam logic       MUL_STALLS = (MUL_LAT > 1);

  state_t                 state_q, state_d;
  logic [3:0]             mul_cnt_q, mul_cnt_d;
  logic [STALL_CNT_W-1:0] stall_q;
  logic [9:0]             ctl;
  logic                   mul_go;

  assign mul_go = mul_start && MUL_STALLS;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      mul_cnt_q <= 4'd0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      if (!en_f && (stall_q != {STALL_CNT_W{1'b1}}))
        stall_q <= stall_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    case (state_q)
      RUN: begin
        if (dcache_miss) begin
          state_d = DMISS;
        end else if (mul_go) begin
          state_d   = MUL;
          mul_cnt_d = MUL_INIT;
        end else if (!branch_taken && !load_use && icache_miss) begin
          state_d = IMISS;
        end
      end
      IMISS: begin
        // A D-miss seen during a refill only takes over once the refill lands.
        if (dcache_miss) begin
          if (icache_ready) state_d = DMISS;
        end else if (mul_go) begin
          state_d = IMISS;
        end else if (branch_taken) begin
          state_d = RUN;
        end else if (!load_use && icache_ready) begin
          state_d = RUN;
        end
      end
      DMISS: begin
        if (dcache_ready) state_d = RUN;
      end
      MUL: begin
        if (mul_cnt_q > 4'd1) begin
          mul_cnt_d = mul_cnt_q - 4'd1;
        end else begin
          mul_cnt_d = 4'd0;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ctl = CTL_RUN;
    case (state_q)
      RUN: begin
        if (dcache_miss)       ctl = CTL_DMISS;
        else if (mul_go)       ctl = CTL_MUL;
        else if (branch_taken) ctl = CTL_BR;
        else if (load_use)     ctl = CTL_LU;
        else if (icache_miss)  ctl = CTL_IMISS;
      end
      IMISS: begin
        if (dcache_miss)       ctl = CTL_DMISS;
        else if (mul_go)       ctl = CTL_MUL;
        else if (branch_taken) ctl = CTL_BR;
        else if (load_use)     ctl = CTL_LU;
        else if (icache_ready) ctl = CTL_RUN;
        else                   ctl = CTL_IMISS;
      end
      DMISS: begin
        if (dcache_ready) ctl = branch_taken ? CTL_BR : CTL_RUN;
        else              ctl = CTL_DMISS;
      end
      MUL: begin
        // The release cycle never redirects: a multiply is not a branch.
        ctl = (mul_cnt_q > 4'd1) ? CTL_MUL : CTL_RUN;
      end
      default: ctl = CTL_RUN;
    endcase
  end

  assign {en_f, en_d, en_a, en_m, en_w, bubble_d, bubble_a, bubble_m, bubble_w, redirect} = ctl;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: per-cycle stimulus tables with hand-derived control words.
module tb_pipe_stall_ctrl;

  localparam logic [9:0] RUNP = 10'b11111_0000_0;
  localparam logic [9:0] DMP  = 10'b00001_0001_0;
  localparam logic [9:0] MULP = 10'b00011_0010_0;
  localparam logic [9:0] BRP  = 10'b11111_1100_1;
  localparam logic [9:0] LUP  = 10'b00111_0100_0;
  localparam logic [9:0] IMP  = 10'b01111_1000_0;

  // Stimulus bits: {dcache_miss, dcache_ready, mul_start, load_use, branch_taken, icache_miss, icache_ready}
  localparam logic [6:0] NO = 7'b0000000;
  localparam logic [6:0] DM = 7'b1000000;
  localparam logic [6:0] DR = 7'b0100000;
  localparam logic [6:0] MS = 7'b0010000;
  localparam logic [6:0] LU = 7'b0001000;
  localparam logic [6:0] BT = 7'b0000100;
  localparam logic [6:0] IM = 7'b0000010;
  localparam logic [6:0] IR = 7'b0000001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic icache_miss = 1'b0, icache_ready = 1'b0, dcache_miss = 1'b0, dcache_ready = 1'b0;
  logic mul_start = 1'b0, load_use = 1'b0, branch_taken = 1'b0;
  logic en_f, en_d, en_a, en_m, en_w, bubble_d, bubble_a, bubble_m, bubble_w, redirect;
  logic [3:0] stall_cycles;
  logic [9:0] obs;

  int total = 0;
  int bad = 0;

  pipe_stall_ctrl #(.MUL_LAT(4), .STALL_CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .icache_miss(icache_miss), .icache_ready(icache_ready),
    .dcache_miss(dcache_miss), .dcache_ready(dcache_ready),
    .mul_start(mul_start), .load_use(load_use), .branch_taken(branch_taken),
    .en_f(en_f), .en_d(en_d), .en_a(en_a), .en_m(en_m), .en_w(en_w),
    .bubble_d(bubble_d), .bubble_a(bubble_a), .bubble_m(bubble_m), .bubble_w(bubble_w),
    .redirect(redirect), .stall_cycles(stall_cycles)
  );

  assign obs = {en_f, en_d, en_a, en_m, en_w, bubble_d, bubble_a, bubble_m, bubble_w, redirect};

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic [6:0] v);
    @(negedge clk);
    {dcache_miss, dcache_ready, mul_start, load_use, branch_taken, icache_miss, icache_ready} = v;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {dcache_miss, dcache_ready, mul_start, load_use, branch_taken, icache_miss, icache_ready} = NO;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    if (obs !== RUNP) begin $display("FAIL reset_ctl got=%b want=%b", obs, RUNP); bad++; end
    total++;
    if (stall_cycles !== 4'd0) begin $display("FAIL reset_stall got=%0d want=0", stall_cycles); bad++; end
    total++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(NO);
      if (obs !== RUNP) begin $display("FAIL idle_c%0d got=%b want=%b", i, obs, RUNP); bad++; end
      total++;
    end
    if (stall_cycles !== 4'd0) begin $display("FAIL idle_stall got=%0d want=0", stall_cycles); bad++; end
    total++;
  endtask

  task automatic test_mul();
    logic [6:0] st [5] = '{MS, MS | DM, MS, MS | BT, NO};
    logic [9:0] ex [5] = '{MULP, MULP, MULP, RUNP, RUNP};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      if (obs !== ex[i]) begin $display("FAIL mul_c%0d got=%b want=%b", i, obs, ex[i]); bad++; end
      total++;
    end
    if (stall_cycles !== 4'd3) begin $display("FAIL mul_stall got=%0d want=3", stall_cycles); bad++; end
    total++;
  endtask

  task automatic test_dmiss();
    logic [6:0] st [7] = '{DM, NO, LU | IM, MS, NO, DR, NO};
    logic [9:0] ex [7] = '{DMP, DMP, DMP, DMP, DMP, RUNP, RUNP};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(st[i]);
      if (obs !== ex[i]) begin $display("FAIL dmiss_c%0d got=%b want=%b", i, obs, ex[i]); bad++; end
      total++;
    end
    if (stall_cycles !== 4'd5) begin $display("FAIL dmiss_stall got=%0d want=5", stall_cycles); bad++; end
    total++;
  endtask

  task automatic test_dmiss_branch();
    logic [6:0] st [3] = '{DM, DR | BT, NO};
    logic [9:0] ex [3] = '{DMP, BRP, RUNP};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      if (obs !== ex[i]) begin $display("FAIL dmbr_c%0d got=%b want=%b", i, obs, ex[i]); bad++; end
      total++;
    end
  endtask

  task automatic test_branch_loaduse();
    logic [6:0] st [3] = '{LU | BT, LU, NO};
    logic [9:0] ex [3] = '{BRP, LUP, RUNP};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      if (obs !== ex[i]) begin $display("FAIL brlu_c%0d got=%b want=%b", i, obs, ex[i]); bad++; end
      total++;
    end
    if (stall_cycles !== 4'd1) begin $display("FAIL brlu_stall got=%0d want=1", stall_cycles); bad++; end
    total++;
  endtask

  task automatic test_imiss_branch();
    logic [6:0] st [5] = '{IM, NO, BT, IR, NO};
    logic [9:0] ex [5] = '{IMP, IMP, BRP, RUNP, RUNP};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      if (obs !== ex[i]) begin $display("FAIL imbr_c%0d got=%b want=%b", i, obs, ex[i]); bad++; end
      total++;
    end
    if (stall_cycles !== 4'd2) begin $display("FAIL imbr_stall got=%0d want=2", stall_cycles); bad++; end
    total++;
  endtask

  task automatic test_imiss_ready();
    logic [6:0] st [6] = '{IM, NO, IR, NO, IM, IR | BT};
    logic [9:0] ex [6] = '{IMP, IMP, RUNP, RUNP, IMP, BRP};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      if (obs !== ex[i]) begin $display("FAIL imrdy_c%0d got=%b want=%b", i, obs, ex[i]); bad++; end
      total++;
    end
  endtask

  task automatic test_imiss_dmiss();
    logic [6:0] st [6] = '{IM, DM, DM | IR, NO, DR, NO};
    logic [9:0] ex [6] = '{IMP, DMP, DMP, DMP, RUNP, RUNP};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      if (obs !== ex[i]) begin $display("FAIL imdm_c%0d got=%b want=%b", i, obs, ex[i]); bad++; end
      total++;
    end
    if (stall_cycles !== 4'd4) begin $display("FAIL imdm_stall got=%0d want=4", stall_cycles); bad++; end
    total++;
  endtask

  task automatic test_dmiss_mul();
    logic [6:0] st [8] = '{DM | MS, MS, DR | MS, MS, MS, MS, MS, NO};
    logic [9:0] ex [8] = '{DMP, DMP, RUNP, MULP, MULP, MULP, RUNP, RUNP};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(st[i]);
      if (obs !== ex[i]) begin $display("FAIL dmmul_c%0d got=%b want=%b", i, obs, ex[i]); bad++; end
      total++;
    end
    if (stall_cycles !== 4'd5) begin $display("FAIL dmmul_stall got=%0d want=5", stall_cycles); bad++; end
    total++;
  endtask

  task automatic test_reset_mid_mul();
    do_reset();
    drive(MS);
    if (obs !== MULP) begin $display("FAIL rmul_c0 got=%b want=%b", obs, MULP); bad++; end
    total++;
    drive(MS);
    if (obs !== MULP) begin $display("FAIL rmul_c1 got=%b want=%b", obs, MULP); bad++; end
    total++;
    @(negedge clk);
    reset = 1'b1;
    mul_start = 1'b0;
    #1;
    if (obs !== RUNP) begin $display("FAIL rmul_inrst got=%b want=%b", obs, RUNP); bad++; end
    total++;
    if (stall_cycles !== 4'd0) begin $display("FAIL rmul_stall got=%0d want=0", stall_cycles); bad++; end
    total++;
    @(negedge clk);
    reset = 1'b0;
    drive(NO);
    if (obs !== RUNP) begin $display("FAIL rmul_after got=%b want=%b", obs, RUNP); bad++; end
    total++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) drive(DM);
    if (obs !== DMP) begin $display("FAIL sat_hold got=%b want=%b", obs, DMP); bad++; end
    total++;
    drive(DR);
    if (obs !== RUNP) begin $display("FAIL sat_release got=%b want=%b", obs, RUNP); bad++; end
    total++;
    if (stall_cycles !== 4'hF) begin $display("FAIL sat_stall got=%0d want=15", stall_cycles); bad++; end
    total++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_dmiss();
    test_dmiss_branch();
    test_branch_loaduse();
    test_imiss_branch();
    test_imiss_ready();
    test_imiss_dmiss();
    test_dmiss_mul();
    test_reset_mid_mul();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage core (F, D, A, M, W). It drives the enable input of every pipeline-register ff bank, plus a per-stage bubble (valid-clear) strobe. It arbitrates between four hazard sources: I-cache miss, D-cache miss, the multi-cycle multiplier and load-use. It also arbitrates branch redirects from A. Small FSM and counters inside; all hazard inputs are sampled combinationally in the current cycle.

Parameters:
MUL_LAT, 4, total cycles a multiply occupies stage A (legal range 1..15; 1 = no stall)
STALL_CNT_W, 16, width of saturating stall-cycle performance counter

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
icache_miss  input  1  fetch in F missed this cycle
icache_ready  input  1  refill done, F data valid this cycle
dcache_miss  input  1  load/store in M missed this cycle
dcache_ready  input  1  D-side refill done this cycle
mul_start  input  1  multiply op present in A (held high while op stays in A)
load_use  input  1  D instr needs result of load currently in A
branch_taken  input  1  instr in A resolves as taken/mispredicted
en_f, en_d, en_a, en_m, en_w  output  1 each  enable for stage pipeline registers
bubble_d, bubble_a, bubble_m, bubble_w  output  1 each  load stage valid=0 at next edge (stage enable is also 1)
redirect  output  1  F loads branch target PC this cycle
stall_cycles  output  STALL_CNT_W  count of cycles with en_f=0, saturating at all-ones

Behaviour:
- Reset is asynchronous and active-high; clock is clk. On reset: state=RUN, mul_cnt=0, stall_cycles=0.
- Outputs are combinational from state and inputs. In RUN with no hazard: all en_*=1, all bubble_*=0, redirect=0.
- States: RUN, IMISS, DMISS, MUL.
- RUN priority, highest first:
  - dcache_miss: en_f..en_m=0, en_w=1, bubble_w=1; next state DMISS.
  - mul_start, MUL_LAT>1: en_f,en_d,en_a=0, en_m=en_w=1, bubble_m=1; mul_cnt<=MUL_LAT-1; next state MUL. With MUL_LAT=1, mul_start is ignored.
  - branch_taken: all en=1, redirect=1, bubble_d=1, bubble_a=1; stay RUN. This overrides load_use and icache_miss.
  - load_use: en_f=en_d=0, bubble_a=1, others advance; stay RUN. Exactly one bubble per assertion cycle.
  - icache_miss: en_f=0, bubble_d=1, D..W advance; next state IMISS.
- DMISS:
  - Output pattern is the same as dcache_miss in RUN.
  - A dcache_ready cycle gives all en=1, no bubbles, and returns to RUN. A branch_taken that cycle is honoured: redirect, bubble_d, bubble_a.
  - mul_start, load_use and icache_miss are ignored in this state.
- MUL:
  - While mul_cnt>1: freeze F..A, bubble_m=1, mul_cnt decrements.
  - When mul_cnt==1: all en=1, no bubbles, return to RUN.
  - mul_start is ignored in this state. dcache_miss is also ignored, because M holds a bubble.
  - branch_taken at release is ignored, since a multiply never branches.
- IMISS:
  - en_f=0, bubble_d=1, D..W advance. dcache_miss, mul_start and load_use are handled as in RUN but the state stays IMISS; a dcache_miss moves to DMISS only after icache_ready.
  - icache_ready: all en=1, return to RUN.
  - branch_taken: redirect=1, en_f=1, bubble_d=bubble_a=1, return to RUN. The outstanding refill is abandoned; the fetch unit discards the late icache_ready.
  - Simultaneous icache_ready and branch_taken: redirect wins.
- Invariants:
  - A bubbled stage always has en=1.
  - A frozen stage never has bubble=1.
  - A stage is never enabled while a later stage is frozen, except that the W bubble may be enabled behind a frozen M.
- stall_cycles increments on every clk where en_f=0, saturates at all-ones, and clears only on reset.
- Reset mid-operation: FSM returns to RUN immediately; a pending mul_cnt or refill is forgotten.

Test Plan:
- Reset, then no hazards for 10 cycles -> all en=1, bubbles=0, stall_cycles=0.
- mul_start held with MUL_LAT=4 -> en_a=0 and bubble_m=1 for 3 cycles, en_a=1 on cycle 4, RUN after; stall_cycles=3.
- dcache_miss in RUN, dcache_ready 5 cycles later -> en_f..en_m=0 and bubble_w=1 for 5 cycles, release cycle all en=1; stall_cycles=5.
- load_use and branch_taken in the same cycle -> redirect=1, bubble_d=bubble_a=1, en_d=1; no load-use bubble.
- icache_miss, then branch_taken 2 cycles later, then a stray icache_ready -> redirect in cycle 2, state RUN, the later icache_ready causes no output change.
- dcache_miss and mul_start in the same cycle -> DMISS taken first; after dcache_ready, mul_start still high gives MUL_LAT-1 freeze cycles. Separately, assert reset mid-MUL -> all en=1 after reset deasserts.
